tri_fetch: RTL

Parametrised successor to the single-request triangle reader. Accepts triangle indices through a ready/valid queue and returns each triangle's NDWORDS x 32-bit block in request order with output backpressure. A direct-mapped read-only cache serves hits; misses are filled over a pipelined Avalon-MM read master. Sits between the ray/triangle intersection front end and the SDRAM controller.

---
 rtl/tri_fetch_pkg.sv | 24 ++
 rtl/tri_req_fifo.sv | 64 ++++++
 rtl/tri_fetch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tri_fetch_pkg.sv
// Shared types and sizing helpers for the triangle fetch path.
// Also used by the planned shading-data fetcher.
package tri_pkg;

    localparam int NDWORDS_DEF = 9;
    localparam int BLOCKSZ_DEF = 32 * NDWORDS_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MISS_RD = 3'd2,
        FILL    = 3'd3,
        RESP    = 3'd4
    } state_t;

    function automatic int calc_nbeats(input int ndwords, input int avm_dw);
        return (32 * ndwords) / avm_dw;
    endfunction

    function automatic int calc_tag_bits(input int index_bits);
        return 32 - index_bits;
    endfunction

endpackage

// File: rtl/tri_req_fifo.sv
// Synchronous FIFO with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tri_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == '0);
    assign rdata = mem_r[rptr_r];

    // Qualify push/pop against occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/tri_fetch.sv
// Triangle block fetcher: queued index requests, direct-mapped read-only cache,
// pipelined Avalon-MM burst-free refill, in-order responses with backpressure.
module tri_fetch
    import tri_pkg::*;
#(
    parameter int NDWORDS    = NDWORDS_DEF,
    parameter int AVM_DW     = 16,
    parameter int INDEX_BITS = 8,
    parameter int REQ_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             baseaddr,
    input  logic                    flush,
    input  logic [31:0]             index,
    input  logic                    ivalid,
    output logic                    iready,
    output logic [32*NDWORDS-1:0]   data,
    output logic                    ovalid,
    input  logic                    oready,
    output logic                    avm_m0_read,
    output logic                    avm_m0_write,
    output logic [AVM_DW-1:0]       avm_m0_writedata,
    output logic [31:0]             avm_m0_address,
    output logic [AVM_DW/8-1:0]     avm_m0_byteenable,
    input  logic [AVM_DW-1:0]       avm_m0_readdata,
    input  logic                    avm_m0_readdatavalid,
    input  logic                    avm_m0_waitrequest
);

    localparam int BLOCKSZ    = 32 * NDWORDS;
    localparam int NBEATS     = calc_nbeats(NDWORDS, AVM_DW);
    localparam int TAG_BITS   = calc_tag_bits(INDEX_BITS);
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int BEAT_BYTES = AVM_DW / 8;
    localparam int CNT_W      = $clog2(NBEATS + 1);

    state_t                state_r;
    logic [31:0]           req_index_r;
    logic [LINES-1:0]      valid_r;
    logic                  line_valid_r;
    logic [BLOCKSZ-1:0]    line_data_r;
    logic [TAG_BITS-1:0]   line_tag_r;
    logic [BLOCKSZ-1:0]    asm_r;
    logic [CNT_W-1:0]      issue_cnt_r;
    logic [CNT_W-1:0]      ret_cnt_r;
    logic                  flush_pending_r;

    logic [BLOCKSZ-1:0]    data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    logic                  q_full_s;
    logic                  q_empty_s;
    logic [31:0]           q_head_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_apply_s;
    logic                  hit_s;
    logic [31:0]           block_base_s;
    logic [INDEX_BITS-1:0] head_line_s;
    logic [INDEX_BITS-1:0] req_line_s;

    assign avm_m0_write      = 1'b0;
    assign avm_m0_writedata  = '0;
    assign avm_m0_byteenable = {(AVM_DW/8){1'b1}};

    assign iready        = !q_full_s && !flush_pending_r;
    assign push_s        = ivalid && iready;
    assign flush_apply_s = (state_r == IDLE) && flush_pending_r;
    assign pop_s         = (state_r == IDLE) && !flush_pending_r && !q_empty_s;
    assign head_line_s   = q_head_s[INDEX_BITS-1:0];
    assign req_line_s    = req_index_r[INDEX_BITS-1:0];
    assign hit_s         = line_valid_r && (line_tag_r == req_index_r[31:INDEX_BITS]);
    assign block_base_s  = baseaddr + req_index_r * 32'(NDWORDS * 4);

    tri_req_fifo #(
        .WIDTH (32),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (index),
        .pop   (pop_s),
        .rdata (q_head_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    // Line storage: registered read on pop, written once per completed refill.
    always_ff @(posedge clk) begin
        if (state_r == FILL) begin
            data_mem[req_line_s] <= asm_r;
            tag_mem[req_line_s]  <= req_index_r[31:INDEX_BITS];
        end
        if (pop_s) begin
            line_data_r <= data_mem[head_line_s];
            line_tag_r  <= tag_mem[head_line_s];
        end
    end

    // Control FSM with registered Avalon and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            req_index_r     <= '0;
            valid_r         <= '0;
            line_valid_r    <= 1'b0;
            asm_r           <= '0;
            issue_cnt_r     <= '0;
            ret_cnt_r       <= '0;
            flush_pending_r <= 1'b0;
            data            <= '0;
            ovalid          <= 1'b0;
            avm_m0_read     <= 1'b0;
            avm_m0_address  <= '0;
        end else begin
            // A flush arriving in the apply cycle stays pending for another pass.
            flush_pending_r <= flush || (flush_pending_r && !flush_apply_s);
            case (state_r)
                IDLE: begin
                    if (flush_pending_r) begin
                        valid_r <= '0;
                    end else if (!q_empty_s) begin
                        req_index_r  <= q_head_s;
                        line_valid_r <= valid_r[head_line_s];
                        state_r      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        data    <= line_data_r;
                        ovalid  <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        avm_m0_read    <= 1'b1;
                        avm_m0_address <= block_base_s;
                        issue_cnt_r    <= '0;
                        ret_cnt_r      <= '0;
                        state_r        <= MISS_RD;
                    end
                end
                MISS_RD: begin
                    if (avm_m0_read && !avm_m0_waitrequest) begin
                        issue_cnt_r    <= issue_cnt_r + 1'b1;
                        avm_m0_address <= avm_m0_address + 32'(BEAT_BYTES);
                        if (issue_cnt_r == CNT_W'(NBEATS - 1)) begin
                            avm_m0_read <= 1'b0;
                        end
                    end
                    if (avm_m0_readdatavalid) begin
                        asm_r[ret_cnt_r * AVM_DW +: AVM_DW] <= avm_m0_readdata;
                        ret_cnt_r <= ret_cnt_r + 1'b1;
                        if (ret_cnt_r == CNT_W'(NBEATS - 1)) begin
                            state_r <= FILL;
                        end
                    end
                end
                FILL: begin
                    valid_r[req_line_s] <= 1'b1;
                    data                <= asm_r;
                    ovalid              <= 1'b1;
                    state_r             <= RESP;
                end
                RESP: begin
                    if (oready) begin
                        ovalid  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
